sc_fifo: RTL

- Single-clock, parametrised FIFO: next generation of the team's FIFO family for same-domain buffering between pipeline stages.
- Generalised beyond power-of-two depth.
- Adds:
  - selectable first-word-fall-through (FWFT) or registered-read mode
  - fill level and programmable almost-full/almost-empty thresholds
  - synchronous flush
  - sticky overflow/underflow error flags

---
 rtl/fifo_pkg.sv | 12 +
 rtl/sc_fifo_ram.sv | 23 ++
 rtl/sc_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: level width and non-power-of-two pointer wrap.
package fifo_pkg;

  function automatic int lw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read with enable, no reset.
module sc_fifo_ram #(
  parameter type T     = logic [15:0],
  parameter int  DEPTH = 8,
  parameter int  AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  T              wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output T              rd_data
);

  T mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO with FWFT or registered-read output, level, thresholds,
// synchronous flush and sticky error flags.
module sc_fifo
  import fifo_pkg::*;
#(
  parameter type T         = logic [15:0],
  parameter int  DEPTH     = 8,
  parameter bit  FWFT      = 1'b1,
  parameter int  AF_THRESH = DEPTH - 1,
  parameter int  AE_THRESH = 1,
  parameter int  LW        = lw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [$bits(T)-1:0] wr_din,
  input  logic                wr_write,
  output logic                wr_full,
  output logic                wr_almost_full,
  output logic                wr_overflow,
  input  logic                rd_read,
  output logic [$bits(T)-1:0] rd_dout,
  output logic                rd_empty,
  output logic                rd_almost_empty,
  output logic                rd_underflow,
  output logic [LW-1:0]       level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $bits(T);

  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, raddr_nxt;
  logic [LW-1:0] level_nxt;
  logic          wr_acc, rd_acc;
  logic          byp_valid;
  logic [DW-1:0] byp_data, ram_eff, dout_nxt;
  T              ram_q;

  sc_fifo_ram #(.T(T), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (T'(wr_din)),
    .rd_en   (1'b1),
    .rd_addr (raddr_nxt),
    .rd_data (ram_q)
  );

  // The RAM prefetches one slot ahead of the head in FWFT mode (the head itself
  // lives in rd_dout) and the head slot in registered mode. A write landing on the
  // address being prefetched is caught by the bypass register.
  always_comb begin
    wr_acc     = wr_write && !wr_full && !flush;
    rd_acc     = rd_read && !rd_empty && !flush;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (wr_acc) wr_ptr_nxt = AW'(next_ptr(int'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr_nxt = AW'(next_ptr(int'(rd_ptr), DEPTH));
      if (wr_acc && !rd_acc) level_nxt = level + LW'(1);
      else if (rd_acc && !wr_acc) level_nxt = level - LW'(1);
    end
    raddr_nxt = FWFT ? AW'(next_ptr(int'(rd_ptr_nxt), DEPTH)) : rd_ptr_nxt;
    ram_eff   = byp_valid ? byp_data : DW'(ram_q);
  end

  // In FWFT mode a write that becomes the head (empty FIFO, or the sole word
  // being popped in the same cycle) goes straight to rd_dout.
  always_comb begin
    dout_nxt = rd_dout;
    if (FWFT) begin
      if (wr_acc && (level == '0 || (level == LW'(1) && rd_acc)))
        dout_nxt = wr_din;
      else if (rd_acc && level >= LW'(2))
        dout_nxt = ram_eff;
    end else if (rd_acc) begin
      dout_nxt = ram_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      wr_full         <= 1'b0;
      rd_empty        <= 1'b1;
      wr_almost_full  <= 1'b0;
      rd_almost_empty <= 1'b1;
      wr_overflow     <= 1'b0;
      rd_underflow    <= 1'b0;
      byp_valid       <= 1'b0;
      byp_data        <= '0;
      rd_dout         <= '0;
    end else begin
      wr_ptr          <= wr_ptr_nxt;
      rd_ptr          <= rd_ptr_nxt;
      level           <= level_nxt;
      wr_full         <= (level_nxt == LW'(DEPTH));
      rd_empty        <= (level_nxt == '0);
      wr_almost_full  <= (level_nxt >= LW'(AF_THRESH));
      rd_almost_empty <= (level_nxt <= LW'(AE_THRESH));
      if (flush) begin
        wr_overflow  <= 1'b0;
        rd_underflow <= 1'b0;
      end else begin
        if (wr_write && wr_full) wr_overflow <= 1'b1;
        if (rd_read && rd_empty) rd_underflow <= 1'b1;
      end
      byp_valid <= wr_acc && (wr_ptr == raddr_nxt);
      byp_data  <= wr_din;
      rd_dout   <= dout_nxt;
    end
  end

endmodule
